// File: rtl/cmd_frame_pkg.sv
// Shared types and constants for the command frame decoder.
package cmd_frame_pkg;

    // Frame parser states; encoding is visible on the decoder's debug port.
    typedef enum logic [2:0] {
        ST_HUNT  = 3'd0,
        ST_LEN   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DATA  = 3'd3,
        ST_ISSUE = 3'd4
    } frame_state_e;

    // Start-of-frame byte used unless the instantiation overrides it.
    localparam logic [7:0] DEFAULT_MAGIC = 8'hAA;

    // Smallest legal payload length; the largest is the decoder's DATA_BYTES.
    localparam logic [7:0] LEN_MIN = 8'd1;

    // True when a received LEN byte names a payload the decoder can hold.
    function automatic logic len_in_range(input logic [7:0] len, input logic [7:0] len_max);
        return (len >= LEN_MIN) && (len <= len_max);
    endfunction

endpackage

// File: rtl/cmd_idle_timer.sv
// Mid-frame idle watchdog: a down-counter reloaded by every accepted byte.
// expire is raised combinationally on the TIMEOUT_CYCLES-th consecutive
// enabled cycle with no clear, so the parser can abort on that same edge.
module cmd_idle_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counter holds the idle cycles still allowed before the expiring one.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = RELOAD;
        end else if (enable && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign expire = enable && !clear && (cnt_q == '0);

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cmd_frame_decoder.sv
// Byte-stream command decoder: MAGIC, LEN, ADDR, LEN payload bytes, then a
// single held register write.
//
// Handshakes: an rx byte transfers on a rising edge where rx_valid && rx_ready;
// a register write transfers on a rising edge where reg_wr && reg_ready. Both
// sides may hold valid/request indefinitely; nothing is consumed otherwise.
module cmd_frame_decoder
    import cmd_frame_pkg::*;
#(
    parameter int unsigned DATA_BYTES     = 8,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter logic [7:0]  MAGIC          = DEFAULT_MAGIC,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic [ADDR_WIDTH-1:0]   reg_addr,
    output logic [8*DATA_BYTES-1:0] reg_data,
    output logic [DATA_BYTES-1:0]   reg_byte_en,
    output logic                    reg_wr,
    input  logic                    reg_ready,
    output logic [15:0]             err_count,
    output logic [15:0]             frame_count,
    output logic [2:0]              dbg_state
);

    localparam logic [7:0] LEN_MAX = 8'(DATA_BYTES);

    frame_state_e              state_q, state_d;
    logic [4:0]                len_q, len_d;
    logic [4:0]                idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [8*DATA_BYTES-1:0]   data_q, data_d;
    logic [DATA_BYTES-1:0]     be_q, be_d;
    logic [15:0]               err_q, err_d;
    logic [15:0]               frame_q, frame_d;

    logic accept;
    logic err_inc;
    logic timer_en;
    logic timer_expire;

    assign rx_ready = (state_q != ST_ISSUE);
    assign accept   = rx_valid && rx_ready;
    assign timer_en = (state_q == ST_LEN) || (state_q == ST_ADDR) || (state_q == ST_DATA);

    cmd_idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (accept),
        .enable  (timer_en),
        .expire  (timer_expire)
    );

    // Next-state and datapath updates for the frame parser.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        frame_d = frame_q;
        err_inc = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (accept && (rx_data == MAGIC)) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    if (len_in_range(rx_data, LEN_MAX)) begin
                        len_d   = rx_data[4:0];
                        idx_d   = '0;
                        data_d  = '0;
                        be_d    = '0;
                        state_d = ST_ADDR;
                    end else begin
                        err_inc = 1'b1;
                        state_d = ST_HUNT;
                    end
                end else if (timer_expire) begin
                    err_inc = 1'b1;
                    state_d = ST_HUNT;
                end
            end
            ST_ADDR: begin
                if (accept) begin
                    addr_d  = ADDR_WIDTH'(rx_data);
                    state_d = ST_DATA;
                end else if (timer_expire) begin
                    err_inc = 1'b1;
                    state_d = ST_HUNT;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    for (int k = 0; k < DATA_BYTES; k++) begin
                        if (idx_q == 5'(k)) begin
                            data_d[8*k +: 8] = rx_data;
                            be_d[k]          = 1'b1;
                        end
                    end
                    idx_d = idx_q + 5'd1;
                    if ((idx_q + 5'd1) == len_q) begin
                        state_d = ST_ISSUE;
                    end
                end else if (timer_expire) begin
                    err_inc = 1'b1;
                    state_d = ST_HUNT;
                end
            end
            ST_ISSUE: begin
                if (reg_ready) begin
                    frame_d = frame_q + 16'd1;
                    state_d = ST_HUNT;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase

        err_d = (err_inc && (err_q != 16'hFFFF)) ? (err_q + 16'd1) : err_q;
    end

    // Parser state and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_HUNT;
            len_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
            err_q   <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            be_q    <= be_d;
            err_q   <= err_d;
            frame_q <= frame_d;
        end
    end

    assign reg_wr      = (state_q == ST_ISSUE);
    assign reg_addr    = addr_q;
    assign reg_data    = data_q;
    assign reg_byte_en = be_q;
    assign err_count   = err_q;
    assign frame_count = frame_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Directed bench for cmd_frame_decoder (DATA_BYTES=8, short timeout).
module tb_cmd_frame_decoder;

  localparam int DB = 8;
  localparam int TO = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]      rx_data = 8'h00;
  logic            rx_valid = 1'b0;
  logic            rx_ready;
  logic [7:0]      reg_addr;
  logic [8*DB-1:0] reg_data;
  logic [DB-1:0]   reg_byte_en;
  logic            reg_wr;
  logic            reg_ready = 1'b1;
  logic [15:0]     err_count;
  logic [15:0]     frame_count;
  logic [2:0]      dbg_state;

  cmd_frame_decoder #(
    .DATA_BYTES     (DB),
    .ADDR_WIDTH     (8),
    .MAGIC          (8'hAA),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .reg_addr    (reg_addr),
    .reg_data    (reg_data),
    .reg_byte_en (reg_byte_en),
    .reg_wr      (reg_wr),
    .reg_ready   (reg_ready),
    .err_count   (err_count),
    .frame_count (frame_count),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [79:0] exp_q[$];
  logic [79:0] wr_q[$];
  logic [15:0] exp_err = 16'd0;
  logic [15:0] exp_frames = 16'd0;

  // Record every write that will complete on the next rising edge.
  always @(negedge clk) begin
    if (reset_n && reg_wr && reg_ready) wr_q.push_back({reg_addr, reg_data, reg_byte_en});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 100 && !rx_ready; i++) tick();
    if (!rx_ready) begin
      errors++;
      checks++;
      $display("FAIL send_byte: rx_ready=%0b required 1 for byte %02h", rx_ready, b);
    end
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    for (int i = 0; i < 50 && wr_q.size() < n; i++) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) tick();
    checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL rst_wr_low: got %0b want 0", reg_wr); end
    checks++; if (reg_byte_en !== 8'h00) begin errors++; $display("FAIL rst_be_low: got %h want 00", reg_byte_en); end
    reset_n = 1'b1;
    tick();
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rst_rx_ready: got %0b want 1", rx_ready); end
    checks++; if (reg_addr !== 8'h00) begin errors++; $display("FAIL rst_addr: got %h want 00", reg_addr); end
    checks++; if (reg_data !== 64'h0) begin errors++; $display("FAIL rst_data: got %h want 0", reg_data); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL rst_err: got %0d want 0", err_count); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL rst_frames: got %0d want 0", frame_count); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_garbage();
    logic [7:0] bytes [7] = '{8'hFF, 8'hFF, 8'hFF, 8'hAA, 8'h01, 8'h01, 8'h01};
    foreach (bytes[i]) send_byte(bytes[i]);
    exp_q.push_back({8'h01, 64'h0000_0000_0000_0001, 8'h01});
    exp_frames = exp_frames + 16'd1;
    wait_writes(1);
    checks++; if (wr_q.size() !== 1) begin errors++; $display("FAIL garbage_wr_count: got %0d want 1", wr_q.size()); end
    while (wr_q.size() > 0 && exp_q.size() > 0) begin
      logic [79:0] got, exp;
      got = wr_q.pop_front(); exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++; $display("FAIL garbage_write: got %h want %h", got, exp); end
    end
    wr_q.delete(); exp_q.delete();
    checks++; if (err_count !== exp_err) begin errors++; $display("FAIL garbage_err: got %0d want %0d", err_count, exp_err); end
    checks++; if (frame_count !== exp_frames) begin errors++; $display("FAIL garbage_frames: got %0d want %0d", frame_count, exp_frames); end
  endtask

  task automatic test_full_payload();
    logic [7:0] bytes [8] = '{8'hAA, 8'h05, 8'h04, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
    foreach (bytes[i]) send_byte(bytes[i]);
    exp_q.push_back({8'h04, 64'h0000_0001_0100_0000, 8'h1F});
    exp_frames = exp_frames + 16'd1;
    wait_writes(1);
    checks++; if (wr_q.size() !== 1) begin errors++; $display("FAIL full_wr_count: got %0d want 1", wr_q.size()); end
    while (wr_q.size() > 0 && exp_q.size() > 0) begin
      logic [79:0] got, exp;
      got = wr_q.pop_front(); exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++; $display("FAIL full_write: got %h want %h", got, exp); end
    end
    wr_q.delete(); exp_q.delete();
    checks++; if (frame_count !== exp_frames) begin errors++; $display("FAIL full_frames: got %0d want %0d", frame_count, exp_frames); end
  endtask

  task automatic test_bad_len();
    send_byte(8'hAA); send_byte(8'h00);
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL badlen0_state: got %0d want 0", dbg_state); end
    send_byte(8'hAA); send_byte(8'h09);
    exp_err = exp_err + 16'd2;
    checks++; if (err_count !== exp_err) begin errors++; $display("FAIL badlen_err: got %0d want %0d", err_count, exp_err); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL badlen9_state: got %0d want 0", dbg_state); end
    checks++; if (wr_q.size() !== 0 || reg_wr !== 1'b0) begin errors++; $display("FAIL badlen_no_wr: got %0d writes wr=%0b want 0", wr_q.size(), reg_wr); end
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02); send_byte(8'h11);
    exp_q.push_back({8'h02, 64'h0000_0000_0000_0011, 8'h01});
    exp_frames = exp_frames + 16'd1;
    wait_writes(1);
    checks++; if (wr_q.size() !== 1) begin errors++; $display("FAIL badlen_wr_count: got %0d want 1", wr_q.size()); end
    while (wr_q.size() > 0 && exp_q.size() > 0) begin
      logic [79:0] got, exp;
      got = wr_q.pop_front(); exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++; $display("FAIL badlen_write: got %h want %h", got, exp); end
    end
    wr_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    int bad = 0;
    reg_ready = 1'b0;
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h07); send_byte(8'h5A); send_byte(8'h3C);
    checks++; if (reg_wr !== 1'b1) begin errors++; $display("FAIL bp_wr_latency: got %0b want 1", reg_wr); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL bp_rx_ready: got %0b want 0", rx_ready); end
    // Offer a byte during the stall; it must not be consumed. Stall beyond the timeout.
    rx_data = 8'hAA; rx_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (reg_wr !== 1'b1 || rx_ready !== 1'b0 || reg_addr !== 8'h07 || reg_data !== 64'h3C5A ||
          reg_byte_en !== 8'h03 || frame_count !== exp_frames || err_count !== exp_err) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
    rx_valid = 1'b0;
    exp_q.push_back({8'h07, 64'h0000_0000_0000_3C5A, 8'h03});
    exp_frames = exp_frames + 16'd1;
    reg_ready = 1'b1;
    tick();
    checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL bp_wr_drop: got %0b want 0", reg_wr); end
    checks++; if (frame_count !== exp_frames) begin errors++; $display("FAIL bp_frames: got %0d want %0d", frame_count, exp_frames); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL bp_state: got %0d want 0", dbg_state); end
    checks++; if (wr_q.size() !== 1) begin errors++; $display("FAIL bp_wr_count: got %0d want 1", wr_q.size()); end
    while (wr_q.size() > 0 && exp_q.size() > 0) begin
      logic [79:0] got, exp;
      got = wr_q.pop_front(); exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++; $display("FAIL bp_write: got %h want %h", got, exp); end
    end
    wr_q.delete(); exp_q.delete();
  endtask

  task automatic test_timeout();
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h03);
    repeat (TO - 1) tick();
    checks++; if (dbg_state !== 3'd3) begin errors++; $display("FAIL to_not_yet: got state %0d want 3", dbg_state); end
    tick();
    exp_err = exp_err + 16'd1;
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL to_state: got %0d want 0", dbg_state); end
    checks++; if (err_count !== exp_err) begin errors++; $display("FAIL to_err: got %0d want %0d", err_count, exp_err); end
    // One cycle short of the limit, the frame must survive.
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h03);
    repeat (TO - 1) tick();
    send_byte(8'h44);
    checks++; if (dbg_state !== 3'd3) begin errors++; $display("FAIL to_survive: got state %0d want 3", dbg_state); end
    send_byte(8'h55);
    exp_q.push_back({8'h03, 64'h0000_0000_0000_5544, 8'h03});
    exp_frames = exp_frames + 16'd1;
    wait_writes(1);
    checks++; if (wr_q.size() !== 1) begin errors++; $display("FAIL to_wr_count: got %0d want 1", wr_q.size()); end
    while (wr_q.size() > 0 && exp_q.size() > 0) begin
      logic [79:0] got, exp;
      got = wr_q.pop_front(); exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++; $display("FAIL to_write: got %h want %h", got, exp); end
    end
    wr_q.delete(); exp_q.delete();
    checks++; if (err_count !== exp_err) begin errors++; $display("FAIL to_err_after: got %0d want %0d", err_count, exp_err); end
  endtask

  task automatic test_reset_mid();
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h07); send_byte(8'h12);
    checks++; if (dbg_state !== 3'd3) begin errors++; $display("FAIL rm_in_data: got state %0d want 3", dbg_state); end
    reset_n = 1'b0;
    #1;
    checks++; if (reg_byte_en !== 8'h00 || reg_addr !== 8'h00 || dbg_state !== 3'd0) begin
      errors++; $display("FAIL rm_async: got be=%h addr=%h state=%0d want 00 00 0", reg_byte_en, reg_addr, dbg_state);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    exp_err = 16'd0;
    exp_frames = 16'd0;
    checks++; if (err_count !== exp_err || frame_count !== exp_frames) begin
      errors++; $display("FAIL rm_counters: got err=%0d frames=%0d want 0 0", err_count, frame_count);
    end
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h01); send_byte(8'h02);
    exp_q.push_back({8'h01, 64'h0000_0000_0000_0002, 8'h01});
    exp_frames = exp_frames + 16'd1;
    wait_writes(1);
    checks++; if (wr_q.size() !== 1) begin errors++; $display("FAIL rm_wr_count: got %0d want 1", wr_q.size()); end
    while (wr_q.size() > 0 && exp_q.size() > 0) begin
      logic [79:0] got, exp;
      got = wr_q.pop_front(); exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++; $display("FAIL rm_write: got %h want %h", got, exp); end
    end
    wr_q.delete(); exp_q.delete();
    checks++; if (err_count !== exp_err || frame_count !== exp_frames) begin
      errors++; $display("FAIL rm_final: got err=%0d frames=%0d want %0d %0d", err_count, frame_count, exp_err, exp_frames);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_garbage();
    test_full_payload();
    test_bad_len();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmd_frame_decoder.md
CMD_FRAME_DECODER -- requirements
Module: cmd_frame_decoder

Interface
REQ-001 Parameter DATA_BYTES, 8, maximum payload bytes per frame (1..16).
REQ-002 Parameter ADDR_WIDTH, 8, register address width (fixed 8 in this generation; one address byte).
REQ-003 Parameter MAGIC, 8'hAA, frame start byte.
REQ-004 Parameter TIMEOUT_CYCLES, 1024, idle cycles mid-frame before abort (>=2).
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 rx_data  in  8  command byte from host FIFO.
REQ-008 rx_valid  in  1  rx_data valid this cycle.
REQ-009 rx_ready  out  1  decoder accepts byte; transfer when rx_valid && rx_ready.
REQ-010 reg_addr  out  8  target register address.
REQ-011 reg_data  out  8*DATA_BYTES  payload, little-endian, byte 0 = first data byte.
REQ-012 reg_byte_en  out  DATA_BYTES  one bit per received payload byte.
REQ-013 reg_wr  out  1  write request, held until reg_ready.
REQ-014 reg_ready  in  1  register file accepts write.
REQ-015 err_count  out  16  saturating count of aborted frames.
REQ-016 frame_count  out  16  wrapping count of issued writes.

Function
REQ-017 Frame = MAGIC, LEN, ADDR, then LEN data bytes; LEN legal range 1..DATA_BYTES.
REQ-018 States: HUNT, LEN, ADDR, DATA, ISSUE; one accepted byte advances at most one state.
REQ-019 HUNT: non-MAGIC bytes discarded silently (not counted); MAGIC -> LEN.
REQ-020 LEN: LEN==0 or LEN>DATA_BYTES -> HUNT, err_count+1; else latch LEN, clear reg_data/reg_byte_en -> ADDR.
REQ-021 ADDR: latch reg_addr -> DATA.
REQ-022 DATA: k-th byte (k from 0) written to reg_data[8k+7:8k], reg_byte_en[k] set; after LEN-th byte -> ISSUE.
REQ-023 Unreceived payload bytes read as zero with byte_en clear.
REQ-024 ISSUE: reg_wr=1 starting the cycle after last data byte accepted (latency 1); reg_addr/data/byte_en stable while reg_wr=1.
REQ-025 ISSUE exits on cycle reg_wr && reg_ready: frame_count+1 -> HUNT; reg_wr low next cycle.
REQ-026 rx_ready=1 in all states except ISSUE, where rx_ready=0.
REQ-027 Idle counter resets on each accepted byte; in LEN/ADDR/DATA, TIMEOUT_CYCLES consecutive cycles without acceptance -> HUNT, err_count+1.
REQ-028 Idle counter inactive in HUNT and ISSUE (reg_ready may stall indefinitely).
REQ-029 MAGIC inside LEN/ADDR/DATA is ordinary data, never resynchronises.
REQ-030 err_count saturates at 16'hFFFF; frame_count wraps to 0.
REQ-031 Timeout and bad-LEN in same cycle impossible (exclusive states); only one err increment per cycle.

Reset
REQ-032 reset_n low: state=HUNT, rx_ready=1 after release, reg_wr=0, reg_addr=0, reg_data=0, reg_byte_en=0, err_count=0, frame_count=0, idle counter=0.
REQ-033 reset_n asserted mid-frame or during ISSUE discards partial/pending frame without counting it.

Structure
REQ-034 Package cmd_frame_pkg holds state enum, default MAGIC, and LEN-range check constant.
REQ-035 Sub-module cmd_idle_timer (parametrised down-counter, clear/enable in, expire out) used once.
REQ-036 No other sub-modules; register file external.

Verification
REQ-037 Garbage: FF FF FF then AA 01 01 01 -> one reg_wr, addr 01, data 0x01, byte_en 0x01, err_count 0.
REQ-038 Full payload: AA 05 04 00 00 00 01 01 -> addr 04, data[39:0]=0x0101000000, byte_en 0x1F, upper bytes 0.
REQ-039 Bad length: AA 00, then AA 09 (DATA_BYTES=8) -> no reg_wr, err_count 2; following AA 01 02 11 -> addr 02 data 0x11.
REQ-040 Backpressure: reg_ready low 20 cycles during ISSUE -> rx_ready 0, reg_wr held, outputs stable, frame_count +1 only after handshake.
REQ-041 Timeout: AA 02 03 then idle TIMEOUT_CYCLES -> HUNT, err_count 1; idle TIMEOUT_CYCLES-1 then byte -> frame completes normally.
REQ-042 Reset mid-DATA, then AA 01 01 02 -> single write addr 01 data 0x02, counters 0/1.
